// File: rtl/me_window_ctrl.sv
// Fetch sequencer for the motion-estimation reference-window shift buffer.
// Optional abort input enabled by defining ME_WIN_ABORT_EN.
module me_window_ctrl #(
   parameter int ADDR_W = 10,
   parameter int ROWS   = 8,
   parameter int SR_V   = 16,
   parameter int CY_W   = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] base_addr_i,
   input  logic [ADDR_W-1:0] stride_i,
   output logic              ref_req_o,
   output logic [ADDR_W-1:0] ref_addr_o,
   input  logic              ref_gnt_i,
`ifdef ME_WIN_ABORT_EN
   input  logic              abort_i,
`endif
   output logic              fifo_shift_o,
   output logic              win_valid_o,
   output logic [CY_W-1:0]   cand_y_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int N_ROWS = ROWS + SR_V - 1;
   localparam int RC_MIN = $clog2(N_ROWS + 1);
   localparam int RC_W   = (RC_MIN > CY_W) ? RC_MIN : CY_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   // Row index of the transfer whose data is being shifted in this cycle.
   typedef struct packed {
      logic            vld;
      logic [RC_W-1:0] row;
   } shift_tag_t;

   state_e              state_q, state_d;
   logic                req_q, req_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic [RC_W-1:0]     row_cnt_q, row_cnt_d;
   shift_tag_t          shift_tag_q, shift_tag_d;
   logic                win_q, win_d;
   logic [CY_W-1:0]     cand_q, cand_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                xfer;
   logic                last_row;
   logic                abort_w;
   logic [RC_W-1:0]     cand_full;

`ifdef ME_WIN_ABORT_EN
   assign abort_w = abort_i;
`else
   assign abort_w = 1'b0;
`endif

   assign xfer      = req_q & ref_gnt_i;
   assign last_row  = (row_cnt_q == RC_W'(N_ROWS - 1));
   assign cand_full = shift_tag_q.row - RC_W'(ROWS - 1);

   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      addr_d          = addr_q;
      stride_d        = stride_q;
      row_cnt_d       = row_cnt_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      shift_tag_d.vld = xfer;
      shift_tag_d.row = row_cnt_q;
      win_d           = shift_tag_q.vld && (shift_tag_q.row >= RC_W'(ROWS - 1));
      cand_d          = win_d ? cand_full[CY_W-1:0] : '0;

      case (state_q)
         S_IDLE: begin
            // busy_q is still high in the done cycle, so a colliding start is dropped.
            if (start_i && !busy_q) begin
               state_d   = S_FETCH;
               req_d     = 1'b1;
               addr_d    = base_addr_i;
               stride_d  = stride_i;
               row_cnt_d = '0;
               busy_d    = 1'b1;
            end
         end
         S_FETCH: begin
            if (xfer) begin
               row_cnt_d = row_cnt_q + RC_W'(1);
               addr_d    = addr_q + stride_q;
            end
            if ((xfer && last_row) || abort_w) begin
               state_d = S_DRAIN;
               req_d   = 1'b0;
               addr_d  = '0;
            end
         end
         S_DRAIN: begin
            // Once no shift is outstanding, the last window is on the outputs now.
            if (!shift_tag_q.vld) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            addr_d  = '0;
         end
      endcase

      if (done_q) begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         addr_q      <= '0;
         stride_q    <= '0;
         row_cnt_q   <= '0;
         shift_tag_q <= '0;
         win_q       <= 1'b0;
         cand_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         row_cnt_q   <= row_cnt_d;
         shift_tag_q <= shift_tag_d;
         win_q       <= win_d;
         cand_q      <= cand_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ref_req_o    = req_q;
   assign ref_addr_o   = addr_q;
   assign fifo_shift_o = shift_tag_q.vld;
   assign win_valid_o  = win_q;
   assign cand_y_o     = cand_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
